// File: rtl/mvu_job_ctrl.sv
// rtl/mvu_job_ctrl.sv - per-MVU job controller with a one-deep pending launch slot
//
// Receives launch requests from the pito core: a one-cycle start pulse plus the
// job config (countdown, precisions, base addresses). The config is latched as the
// active job, which runs for countdown+1 cycles, then spends one DONE cycle that
// pulses done and raises irq. A start arriving while a job runs is parked in a
// one-deep pending slot. A start that finds the slot full is dropped and flagged
// in ovf_err.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      launch pulse; cfg inputs are sampled in the same cycle
//   countdown_i                job length minus one
//   wprec_i/iprec_i/oprec_i    weight/input/output precisions
//   wbase_i, ibase_i, obase_i  weight/input/output memory base addresses
//   irq_ack, err_clr           clear irq / clear ovf_err
//   busy, run_en, done         state != IDLE, state == RUN, state == DONE
//   irq                        level, set on job completion, cleared by irq_ack
//   pend_valid, ovf_err        pending slot occupied, sticky dropped-start flag
//   remaining                  active down-counter
//   cfg_*                      active job config, stable for the whole run
//   job_cnt                    completed-job counter, wraps

module mvu_job_ctrl #(
    parameter int BCNTDWN = 29,
    parameter int BPREC   = 6,
    parameter int BBWADDR = 9,
    parameter int BBDADDR = 15,
    parameter int BJOBCNT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BCNTDWN-1:0] countdown_i,
    input  logic [BPREC-1:0]   wprec_i,
    input  logic [BPREC-1:0]   iprec_i,
    input  logic [BPREC-1:0]   oprec_i,
    input  logic [BBWADDR-1:0] wbase_i,
    input  logic [BBDADDR-1:0] ibase_i,
    input  logic [BBDADDR-1:0] obase_i,
    input  logic               irq_ack,
    input  logic               err_clr,
    output logic               busy,
    output logic               run_en,
    output logic               done,
    output logic               irq,
    output logic               pend_valid,
    output logic               ovf_err,
    output logic [BCNTDWN-1:0] remaining,
    output logic [BPREC-1:0]   cfg_wprec,
    output logic [BPREC-1:0]   cfg_iprec,
    output logic [BPREC-1:0]   cfg_oprec,
    output logic [BBWADDR-1:0] cfg_wbase,
    output logic [BBDADDR-1:0] cfg_ibase,
    output logic [BBDADDR-1:0] cfg_obase,
    output logic [BJOBCNT-1:0] job_cnt
);

    // Config fields other than the countdown travel as one packed word so the
    // active and pending copies stay in lockstep.
    localparam int CFGW = 3 * BPREC + BBWADDR + 2 * BBDADDR;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CFGW-1:0]    cfg_q;
    logic [BCNTDWN-1:0] remaining_q;
    logic [CFGW-1:0]    pend_cfg_q;
    logic [BCNTDWN-1:0] pend_cd_q;
    logic               pend_valid_q;
    logic               irq_q;
    logic               ovf_err_q;
    logic [BJOBCNT-1:0] job_cnt_q;

    logic [CFGW-1:0]    cfg_in;
    logic               ovf_set;
    logic               irq_set;

    assign cfg_in  = {wprec_i, iprec_i, oprec_i, wbase_i, ibase_i, obase_i};
    // A start only overflows while running; in DONE the slot is being freed by
    // promotion, so the new request always fits.
    assign ovf_set = (state_q == S_RUN) && start && pend_valid_q;
    assign irq_set = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            remaining_q  <= '0;
            pend_cfg_q   <= '0;
            pend_cd_q    <= '0;
            pend_valid_q <= 1'b0;
            irq_q        <= 1'b0;
            ovf_err_q    <= 1'b0;
            job_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_q       <= cfg_in;
                        remaining_q <= countdown_i;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (remaining_q != '0) begin
                        remaining_q <= remaining_q - BCNTDWN'(1);
                    end else begin
                        state_q <= S_DONE;
                    end
                    if (start && !pend_valid_q) begin
                        pend_cfg_q   <= cfg_in;
                        pend_cd_q    <= countdown_i;
                        pend_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    job_cnt_q <= job_cnt_q + BJOBCNT'(1);
                    if (pend_valid_q) begin
                        cfg_q       <= pend_cfg_q;
                        remaining_q <= pend_cd_q;
                        state_q     <= S_RUN;
                        // A start here refills the slot that promotion just freed.
                        if (start) begin
                            pend_cfg_q <= cfg_in;
                            pend_cd_q  <= countdown_i;
                        end else begin
                            pend_valid_q <= 1'b0;
                        end
                    end else if (start) begin
                        cfg_q       <= cfg_in;
                        remaining_q <= countdown_i;
                        state_q     <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end

            if (ovf_set) begin
                ovf_err_q <= 1'b1;
            end else if (err_clr) begin
                ovf_err_q <= 1'b0;
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign run_en     = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign irq        = irq_q;
    assign pend_valid = pend_valid_q;
    assign ovf_err    = ovf_err_q;
    assign remaining  = remaining_q;
    assign job_cnt    = job_cnt_q;
    assign {cfg_wprec, cfg_iprec, cfg_oprec, cfg_wbase, cfg_ibase, cfg_obase} = cfg_q;

endmodule

// File: tb/tb_mvu_job_ctrl.sv
// tb/tb_mvu_job_ctrl.sv - scoreboard bench for mvu_job_ctrl

module tb_mvu_job_ctrl;

    localparam int BCNTDWN = 29;
    localparam int BPREC   = 6;
    localparam int BBWADDR = 9;
    localparam int BBDADDR = 15;
    localparam int BJOBCNT = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [BCNTDWN-1:0] countdown_i = '0;
    logic [BPREC-1:0]   wprec_i = '0, iprec_i = '0, oprec_i = '0;
    logic [BBWADDR-1:0] wbase_i = '0;
    logic [BBDADDR-1:0] ibase_i = '0, obase_i = '0;
    logic               irq_ack = 1'b0, err_clr = 1'b0;
    logic               busy, run_en, done, irq, pend_valid, ovf_err;
    logic [BCNTDWN-1:0] remaining;
    logic [BPREC-1:0]   cfg_wprec, cfg_iprec, cfg_oprec;
    logic [BBWADDR-1:0] cfg_wbase;
    logic [BBDADDR-1:0] cfg_ibase, cfg_obase;
    logic [BJOBCNT-1:0] job_cnt;

    mvu_job_ctrl #(
        .BCNTDWN(BCNTDWN), .BPREC(BPREC), .BBWADDR(BBWADDR),
        .BBDADDR(BBDADDR), .BJOBCNT(BJOBCNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .countdown_i(countdown_i),
        .wprec_i(wprec_i), .iprec_i(iprec_i), .oprec_i(oprec_i),
        .wbase_i(wbase_i), .ibase_i(ibase_i), .obase_i(obase_i),
        .irq_ack(irq_ack), .err_clr(err_clr),
        .busy(busy), .run_en(run_en), .done(done), .irq(irq),
        .pend_valid(pend_valid), .ovf_err(ovf_err), .remaining(remaining),
        .cfg_wprec(cfg_wprec), .cfg_iprec(cfg_iprec), .cfg_oprec(cfg_oprec),
        .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase), .cfg_obase(cfg_obase),
        .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int wprec;
        int wbase;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: measures each job's RUN length and config, compares at done.
    int run_len = 0;
    int run_wprec = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (run_en) begin
                if (run_len == 0) run_wprec = int'(cfg_wprec);
                else chk("cfg_stable", cfg_wprec, run_wprec);
                run_len++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("run_len", run_len, e.len);
                    chk("done_wprec", cfg_wprec, e.wprec);
                    chk("done_wbase", cfg_wbase, e.wbase);
                end
                run_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int cd, input int wp, input int wb, input bit expect_run);
        exp_t e;
        start       = 1'b1;
        countdown_i = BCNTDWN'(cd);
        wprec_i     = BPREC'(wp);
        iprec_i     = BPREC'(wp + 1);
        oprec_i     = BPREC'(wp + 2);
        wbase_i     = BBWADDR'(wb);
        ibase_i     = BBDADDR'(wb * 3);
        obase_i     = BBDADDR'(wb * 5);
        if (expect_run) begin
            e.len = cd + 1; e.wprec = wp; e.wbase = wb;
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (done) return;
            tick();
        end
        chk("wait_done_timeout", 0, 1);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        chk("rst_pend", pend_valid, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_job_cnt", job_cnt, 0);
        rst_n = 1'b1;
        tick();

        // T1: countdown 3 -> 4 RUN cycles, then done, irq, job_cnt 1
        drive_start(3, 1, 5, 1'b1);
        chk("t1_run_en", run_en, 1);
        chk("t1_remaining", remaining, 3);
        wait_done();
        chk("t1_irq_in_done", irq, 0);
        tick();
        chk("t1_irq", irq, 1);
        chk("t1_job_cnt", job_cnt, 1);
        chk("t1_idle", busy, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("t1_irq_ack", irq, 0);

        // T2 + T4: countdown 0 -> single RUN cycle; ack colliding with set
        drive_start(0, 2, 0, 1'b1);
        chk("t2_cfg_wprec", cfg_wprec, 2);
        chk("t2_cfg_iprec", cfg_iprec, 3);
        wait_done();
        irq_ack = 1'b1;
        tick();
        chk("t4_set_wins", irq, 1);
        tick();
        irq_ack = 1'b0;
        chk("t4_ack_clears", irq, 0);
        chk("t2_job_cnt", job_cnt, 2);

        // T3: A running, B pending, C dropped
        drive_start(5, 1, 1, 1'b1);
        drive_start(2, 3, 7, 1'b1);
        chk("t3_pend", pend_valid, 1);
        chk("t3_ovf_before", ovf_err, 0);
        drive_start(9, 4, 9, 1'b0);
        chk("t3_ovf", ovf_err, 1);
        chk("t3_pend_kept", pend_valid, 1);
        chk("t3_active_wbase", cfg_wbase, 1);
        chk("t3_remaining", remaining, 3);
        wait_done();
        tick();
        chk("t3_pend_promoted", pend_valid, 0);
        chk("t3_b_wbase", cfg_wbase, 7);
        chk("t3_b_remaining", remaining, 2);
        chk("t3_b_obase", cfg_obase, 35);
        wait_done();
        tick();
        chk("t3_c_never_runs", busy, 0);
        chk("t3_job_cnt_wrap", job_cnt, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", ovf_err, 0);

        // T5: reset mid-run with pending
        drive_start(10, 5, 3, 1'b1);
        drive_start(1, 6, 4, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        chk("t5_busy", busy, 0);
        chk("t5_pend", pend_valid, 0);
        chk("t5_irq", irq, 0);
        chk("t5_remaining", remaining, 0);
        chk("t5_cfg_wbase", cfg_wbase, 0);
        rst_n = 1'b1;
        tick(); tick();
        chk("t5_no_done", done, 0);
        chk("t5_still_idle", busy, 0);

        // T6: five back-to-back jobs, start issued in each DONE cycle
        drive_start(1, 1, 11, 1'b1);
        for (int j = 2; j <= 5; j++) begin
            wait_done();
            drive_start(1, j, 10 + j, 1'b1);
            chk("t6_no_gap", run_en, 1);
        end
        wait_done();
        tick();
        chk("t6_job_cnt_wrap", job_cnt, 1);
        chk("t6_idle", busy, 0);
        chk("t6_no_ovf", ovf_err, 0);

        tick();
        chk("leftover_expect", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
